fwd_hazard_tracker: RTL and testbench
=====================================

// Module: fwd_hazard_tracker
// PURPOSE
//  Parametrised forwarding and load-use hazard unit for the EX stage.
//  Keeps an internal shadow pipeline of in-flight writers (MEM, WB, ... up to DEPTH stages past EX).
//  Per source operand, it drives a forward-select for the instruction in EX and a stall request for the instruction in ID.
//  Supports multi-cycle producer latency and flushes.
// PARAMETERS
//  NREG   8   architectural register count; RW=$clog2(NREG); register 0 never forwarded
//  NSRC   2   source operands per instruction
//  DEPTH  2   tracked stages after EX (1=MEM, 2=WB, ...); SW=$clog2(DEPTH+1)
//  CNTW   16  perf counter width (FWD_PERF_EN only)
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high reset
//  ex_valid   in   1        real (non-bubble) instruction in EX this cycle
//  ex_rd      in   RW       EX destination register
//  ex_regwr   in   1        EX instruction writes ex_rd
//  ex_lat     in   SW       stage index at which EX result is first forwardable (1=MEM, 2=WB)
//  ex_flush   in   1        kill EX instruction; it enters tracker as bubble
//  ex_rs      in   NSRC*RW  EX source registers, operand i at [i*RW +: RW]
//  id_rs      in   NSRC*RW  ID source registers
//  id_rs_used in   NSRC     ID operand i actually read
//  fwd_sel    out  NSRC*SW  per EX operand: 0 = register file, k = value from stage k
//  stall      out  1        hold ID/IF; pipeline inserts bubble into EX next cycle
//  fwd_err    out  1        sticky: EX needed a value not yet available
//  stall_cnt  out  CNTW     FWD_PERF_EN only
//  fwd_cnt    out  CNTW     FWD_PERF_EN only
// BEHAVIOUR
//  - Tracker entry s[k], k=1..DEPTH, holds {v, rd, lat}.
//  - Every clock: s[k+1] <= s[k]; s[1] <= {ex_valid & ex_regwr & ~ex_flush & (ex_rd!=0), ex_rd, lat'}.
//    lat' is ex_lat clamped to 1..DEPTH: 0 becomes 1, >DEPTH becomes DEPTH.
//  - Tracker shifts unconditionally. On stall, the pipeline presents ex_valid=0.
//  - fwd_sel[i]: combinational from state and ex_rs, 0-cycle latency.
//    Let k be the smallest index with s[k].v and s[k].rd==ex_rs[i], so the youngest writer wins.
//    If s[k].lat<=k, fwd_sel[i]=k; else fwd_sel[i]=0 and fwd_err sets on the next edge.
//    ex_rs[i]==0 or no match gives 0.
//  - stall: combinational. Asserted if, for any i with id_rs_used[i] and id_rs[i]!=0, the youngest prospective writer is not ready one stage later:
//    EX itself (ex_valid, ex_regwr, ~ex_flush, ex_rd match) with lat'>1, or
//    else the smallest matching s[k] with s[k].lat>k+1.
//    An older match hidden by a younger ready one never stalls.
//  - Default DEPTH=2, lat 2 for loads: a load immediately followed by a user stalls exactly one cycle, then fwd_sel=2 (WB).
//  - ex_flush masks the EX writer in both tracker capture and stall evaluation.
//  - fwd_err: sticky, cleared only by reset.
//  - Reset (sync): all s[k].v=0 and fwd_err=0, hence fwd_sel=0 and stall=0 the cycle after reset.
//    Reset mid-stream discards all in-flight entries. Counters go to 0.
// CONFIGURATION
//  FWD_PERF_EN defined:
//   - stall_cnt increments each cycle stall=1.
//   - fwd_cnt adds the number of operands with fwd_sel!=0 each cycle.
//   - Both saturate at all-ones and clear on reset.
//  FWD_PERF_EN undefined: stall_cnt/fwd_cnt ports absent; no counter logic.
// TESTING
//  1. EX: add rd=3 lat=1; next cycle ex_rs0=3 -> fwd_sel0=1. Cycle after, ex_rs1=3 -> fwd_sel1=2. Then -> 0.
//  2. EX: load rd=5 lat=2; id_rs0=5 used -> stall=1 for one cycle.
//     Bubble follows; user in EX sees fwd_sel0=2; stall_cnt=1.
//  3. s[1] rd=4 and s[2] rd=4 both valid; ex_rs0=4 -> fwd_sel0=1 (youngest wins).
//  4. ex_rd=0 ex_regwr=1; later ex_rs0=0 -> fwd_sel0=0, no stall.
//     Load rd=6 with ex_flush=1; id_rs0=6 -> stall=0.
//  5. Force EX lat=2 writer rd=2, suppress stall, then ex_rs0=2 -> fwd_sel0=0.
//     fwd_err=1 and stays 1 until reset.
//  6. DEPTH=3, NSRC=3: lat=3 producer rd=7; ID user one behind -> 2 stall cycles.
//     Reset asserted during the stall -> stall=0 and all fwd_sel=0 after the edge.

Source files
------------

// File: rtl/fwd_hazard_tracker_if.sv
// EX/ID hazard-tracker bus: pipeline side (master) drives stage info, tracker (slave) returns forwarding/stall.
// Counter signals exist only when FWD_PERF_EN is defined.
interface fwd_hazard_tracker_if #(
    parameter int NREG  = 8,
    parameter int NSRC  = 2,
    parameter int DEPTH = 2
`ifdef FWD_PERF_EN
    , parameter int CNTW = 16
`endif
) ();
    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(DEPTH + 1);

    logic                ex_valid;
    logic [RW-1:0]       ex_rd;
    logic                ex_regwr;
    logic [SW-1:0]       ex_lat;
    logic                ex_flush;
    logic [NSRC*RW-1:0]  ex_rs;
    logic [NSRC*RW-1:0]  id_rs;
    logic [NSRC-1:0]     id_rs_used;
    logic [NSRC*SW-1:0]  fwd_sel;
    logic                stall;
    logic                fwd_err;
`ifdef FWD_PERF_EN
    logic [CNTW-1:0]     stall_cnt;
    logic [CNTW-1:0]     fwd_cnt;
`endif

    modport master (
        output ex_valid, ex_rd, ex_regwr, ex_lat, ex_flush, ex_rs, id_rs, id_rs_used,
        input  fwd_sel, stall, fwd_err
`ifdef FWD_PERF_EN
        , input stall_cnt, fwd_cnt
`endif
    );

    modport slave (
        input  ex_valid, ex_rd, ex_regwr, ex_lat, ex_flush, ex_rs, id_rs, id_rs_used,
        output fwd_sel, stall, fwd_err
`ifdef FWD_PERF_EN
        , output stall_cnt, fwd_cnt
`endif
    );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Forwarding-select and load-use stall unit with a shadow pipeline of in-flight writers past EX.
// Optional saturating perf counters are built when FWD_PERF_EN is defined.
module fwd_hazard_tracker #(
    parameter int NREG  = 8,
    parameter int NSRC  = 2,
    parameter int DEPTH = 2
`ifdef FWD_PERF_EN
    , parameter int CNTW = 16
`endif
) (
    input logic               clk,
    input logic               reset,
    fwd_hazard_tracker_if.slave bus
);
    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(DEPTH + 1);

    logic [DEPTH:1] s_v;
    logic [RW-1:0]  s_rd  [1:DEPTH];
    logic [SW-1:0]  s_lat [1:DEPTH];

    logic               ex_wr;
    logic [SW-1:0]      ex_lat_c;
    logic [NSRC*SW-1:0] fwd_sel_c;
    logic               err_req;
    logic               stall_c;
    logic               fwd_err_q;

    always_comb begin
        ex_wr = bus.ex_valid & bus.ex_regwr & ~bus.ex_flush & (bus.ex_rd != '0);
        if (bus.ex_lat == '0)
            ex_lat_c = SW'(1);
        else if (int'(bus.ex_lat) > DEPTH)
            ex_lat_c = SW'(DEPTH);
        else
            ex_lat_c = bus.ex_lat;
    end

    // Scanning from oldest to youngest lets the youngest matching writer overwrite the result.
    always_comb begin : fwd_comb
        int            hit;
        logic [SW-1:0] hit_lat;
        fwd_sel_c = '0;
        err_req   = 1'b0;
        hit       = 0;
        hit_lat   = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit     = 0;
            hit_lat = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (s_v[k] && (s_rd[k] == bus.ex_rs[i*RW +: RW]) && (bus.ex_rs[i*RW +: RW] != '0)) begin
                    hit     = k;
                    hit_lat = s_lat[k];
                end
            end
            if (hit != 0) begin
                if (int'(hit_lat) <= hit)
                    fwd_sel_c[i*SW +: SW] = SW'(hit);
                else
                    err_req = 1'b1;
            end
        end
    end

    always_comb begin : stall_comb
        int            hit;
        logic [SW-1:0] hit_lat;
        stall_c = 1'b0;
        hit     = 0;
        hit_lat = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit     = 0;
            hit_lat = '0;
            if (bus.id_rs_used[i] && (bus.id_rs[i*RW +: RW] != '0)) begin
                if (ex_wr && (bus.ex_rd == bus.id_rs[i*RW +: RW])) begin
                    if (ex_lat_c > SW'(1))
                        stall_c = 1'b1;
                end else begin
                    for (int k = DEPTH; k >= 1; k--) begin
                        if (s_v[k] && (s_rd[k] == bus.id_rs[i*RW +: RW])) begin
                            hit     = k;
                            hit_lat = s_lat[k];
                        end
                    end
                    // The ID instruction reaches EX one cycle later, so the writer will sit at hit+1.
                    if ((hit != 0) && (int'(hit_lat) > hit + 1))
                        stall_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_v       <= '0;
            fwd_err_q <= 1'b0;
            for (int k = 1; k <= DEPTH; k++) begin
                s_rd[k]  <= '0;
                s_lat[k] <= '0;
            end
        end else begin
            s_v[1]   <= ex_wr;
            s_rd[1]  <= bus.ex_rd;
            s_lat[1] <= ex_lat_c;
            for (int k = 2; k <= DEPTH; k++) begin
                s_v[k]   <= s_v[k-1];
                s_rd[k]  <= s_rd[k-1];
                s_lat[k] <= s_lat[k-1];
            end
            if (err_req)
                fwd_err_q <= 1'b1;
        end
    end

    assign bus.fwd_sel = fwd_sel_c;
    assign bus.stall   = stall_c;
    assign bus.fwd_err = fwd_err_q;

`ifdef FWD_PERF_EN
    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] fwd_cnt_q;
    logic [CNTW:0]   fwd_sum;
    int              nfwd;

    always_comb begin
        nfwd = 0;
        for (int i = 0; i < NSRC; i++)
            if (fwd_sel_c[i*SW +: SW] != '0)
                nfwd = nfwd + 1;
        fwd_sum = {1'b0, fwd_cnt_q} + (CNTW+1)'(nfwd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            fwd_cnt_q <= fwd_sum[CNTW] ? '1 : fwd_sum[CNTW-1:0];
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed-vector bench for fwd_hazard_tracker: DEPTH=2/NSRC=2 and DEPTH=3/NSRC=3 instances.
module tb_fwd_hazard_tracker;
    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    fwd_hazard_tracker_if #(.NREG(8), .NSRC(2), .DEPTH(2)
`ifdef FWD_PERF_EN
        , .CNTW(16)
`endif
    ) b2 ();
    fwd_hazard_tracker_if #(.NREG(8), .NSRC(3), .DEPTH(3)
`ifdef FWD_PERF_EN
        , .CNTW(16)
`endif
    ) b3 ();

    fwd_hazard_tracker #(.NREG(8), .NSRC(2), .DEPTH(2)
`ifdef FWD_PERF_EN
        , .CNTW(16)
`endif
    ) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

    fwd_hazard_tracker #(.NREG(8), .NSRC(3), .DEPTH(3)
`ifdef FWD_PERF_EN
        , .CNTW(16)
`endif
    ) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic [2:0] rd, input logic wr, input logic [1:0] lat,
                          input logic fl, input logic [5:0] rs, input logic [5:0] ids, input logic [1:0] used);
        b2.ex_valid = v;  b2.ex_rd = rd;  b2.ex_regwr = wr;  b2.ex_lat = lat;  b2.ex_flush = fl;
        b2.ex_rs = rs;    b2.id_rs = ids; b2.id_rs_used = used;
        #1;
    endtask

    task automatic drive3(input logic v, input logic [2:0] rd, input logic [1:0] lat,
                          input logic [8:0] rs, input logic [8:0] ids, input logic [2:0] used);
        b3.ex_valid = v;  b3.ex_rd = rd;  b3.ex_regwr = v;  b3.ex_lat = lat;  b3.ex_flush = 1'b0;
        b3.ex_rs = rs;    b3.id_rs = ids; b3.id_rs_used = used;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive2(0, 0, 0, 0, 0, 0, 0, 0);
        drive3(0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_fwd_sel", 32'(b2.fwd_sel), 0);
        check("rst_stall",   32'(b2.stall), 0);
        check("rst_fwd_err", 32'(b2.fwd_err), 0);

        // add rd=3 lat=1, then consumers one and two cycles behind
        drive2(1, 3, 1, 1, 0, 0, 0, 0);                tick();
        drive2(0, 0, 0, 0, 0, {3'd0, 3'd3}, 0, 0);
        check("t1_mem_fwd", 32'(b2.fwd_sel), 32'b0001); tick();
        drive2(0, 0, 0, 0, 0, {3'd3, 3'd0}, 0, 0);
        check("t1_wb_fwd", 32'(b2.fwd_sel), 32'b1000);  tick();
        check("t1_gone", 32'(b2.fwd_sel), 0);            tick();

        // load rd=5 lat=2 with dependent instruction in ID
        drive2(1, 5, 1, 2, 0, 0, {3'd0, 3'd5}, 2'b01);
        check("t2_stall", 32'(b2.stall), 1);             tick();
        drive2(0, 0, 0, 0, 0, 0, {3'd0, 3'd5}, 2'b01);
        check("t2_bubble_nostall", 32'(b2.stall), 0);    tick();
        drive2(0, 0, 0, 0, 0, {3'd0, 3'd5}, 0, 0);
        check("t2_wb_fwd", 32'(b2.fwd_sel), 32'b0010);
`ifdef FWD_PERF_EN
        check("t2_stall_cnt", 32'(b2.stall_cnt), 1);
        check("t2_fwd_cnt",   32'(b2.fwd_cnt), 2);
`endif
        tick();

        // two writers of r4; youngest (lat=1) wins
        drive2(1, 4, 1, 2, 0, 0, 0, 0);                  tick();
        drive2(1, 4, 1, 1, 0, 0, {3'd0, 3'd4}, 2'b01);
        check("t3_ready_ex_nostall", 32'(b2.stall), 0);  tick();
        drive2(0, 0, 0, 0, 0, {3'd4, 3'd4}, 0, 0);
        check("t3_youngest", 32'(b2.fwd_sel), 32'b0101); tick();
        drive2(0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_no_err", 32'(b2.fwd_err), 0);          tick(); tick();

        // latency clamping: 3 -> 2 and 0 -> 1
        drive2(1, 1, 1, 3, 0, 0, 0, 0);                  tick();
        drive2(0, 0, 0, 0, 0, 0, 0, 0);                  tick();
        drive2(0, 0, 0, 0, 0, {3'd0, 3'd1}, 0, 0);
        check("clamp_hi_fwd", 32'(b2.fwd_sel), 32'b0010); tick();
        drive2(1, 1, 1, 0, 0, 0, {3'd0, 3'd1}, 2'b01);
        check("clamp_hi_no_err", 32'(b2.fwd_err), 0);
        check("clamp_lo_nostall", 32'(b2.stall), 0);     tick();
        drive2(0, 0, 0, 0, 0, {3'd0, 3'd1}, 0, 0);
        check("clamp_lo_fwd", 32'(b2.fwd_sel), 32'b0001); tick();

        // r0 writer never tracked; flushed load never stalls
        drive2(1, 0, 1, 1, 0, 0, 0, 2'b01);
        check("t4_r0_nostall", 32'(b2.stall), 0);        tick();
        drive2(0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_r0_fwd", 32'(b2.fwd_sel), 0);          tick();
        drive2(1, 6, 1, 2, 1, 0, {3'd0, 3'd6}, 2'b01);
        check("t4_flush_nostall", 32'(b2.stall), 0);     tick();
        drive2(0, 0, 0, 0, 0, {3'd0, 3'd6}, {3'd0, 3'd6}, 2'b01);
        check("t4_flush_fwd", 32'(b2.fwd_sel), 0);
        check("t4_flush_stall", 32'(b2.stall), 0);       tick();
        drive2(0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_err_clear", 32'(b2.fwd_err), 0);

        // lat=2 writer consumed too early with stall suppressed
        drive2(1, 2, 1, 2, 0, 0, 0, 0);                  tick();
        drive2(0, 0, 0, 0, 0, {3'd0, 3'd2}, 0, 0);
        check("t5_early_fwd", 32'(b2.fwd_sel), 0);       tick();
        drive2(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_err_set", 32'(b2.fwd_err), 1);         tick(); tick(); tick();
        check("t5_err_sticky", 32'(b2.fwd_err), 1);
        reset = 1'b1; tick(); reset = 1'b0; #1;
        check("t5_err_reset", 32'(b2.fwd_err), 0);

        // DEPTH=3: lat=3 producer with user directly behind
        drive3(1, 7, 3, 0, {6'd0, 3'd7}, 3'b001);
        check("t6_stall_1", 32'(b3.stall), 1);           tick();
        drive3(0, 0, 0, 0, {6'd0, 3'd7}, 3'b001);
        check("t6_stall_2", 32'(b3.stall), 1);           tick();
        check("t6_stall_end", 32'(b3.stall), 0);         tick();
        drive3(0, 0, 0, {6'd0, 3'd7}, 0, 0);
        check("t6_fwd3", 32'(b3.fwd_sel), 32'd3);        tick();

        // older unready r7 hidden by a younger ready writer
        drive3(1, 7, 3, 0, 0, 0);                        tick();
        drive3(1, 7, 1, 0, {6'd0, 3'd7}, 3'b001);
        check("t6_hidden_ex", 32'(b3.stall), 0);         tick();
        drive3(0, 0, 0, {6'd0, 3'd7}, {6'd0, 3'd7}, 3'b001);
        check("t6_hidden_s1", 32'(b3.stall), 0);
        check("t6_hidden_fwd", 32'(b3.fwd_sel), 32'd1);  tick();
        drive3(0, 0, 0, 0, 0, 0);                        tick(); tick();
        check("t6_no_err", 32'(b3.fwd_err), 0);

        // reset in the middle of the two-cycle stall
        drive3(1, 7, 3, 0, {6'd0, 3'd7}, 3'b001);
        check("t6r_stall_1", 32'(b3.stall), 1);          tick();
        drive3(0, 0, 0, 0, {6'd0, 3'd7}, 3'b001);
        check("t6r_stall_2", 32'(b3.stall), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        drive3(0, 0, 0, {3'd7, 3'd7, 3'd7}, {6'd0, 3'd7}, 3'b001);
        check("t6r_stall_after", 32'(b3.stall), 0);
        check("t6r_fwd_after", 32'(b3.fwd_sel), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
